// File: rtl/run_ctrl_pkg.sv
// Shared types and default program map for the run sequencer.
// START/END entries are the assembler's program layout; prog_tbl trims them to D bits.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      RUN    = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam int MAX_PROG = 8;

   localparam logic [15:0] START_DEF [MAX_PROG] = '{
      16'h000, 16'h040, 16'h080, 16'h100, 16'h180, 16'h200, 16'h280, 16'h300
   };

   localparam logic [15:0] END_DEF [MAX_PROG] = '{
      16'h010, 16'h050, 16'h0a0, 16'h120, 16'h1a0, 16'h220, 16'h2a0, 16'h320
   };

   localparam logic SEL_ERR_BAD = 1'b1;

endpackage

// File: rtl/run_ctrl_prog_tbl.sv
// Program index to {entry, end} address lookup; regenerated by the assembler.
// Indices at or above NPROG decode to address 0.
module prog_tbl
   import run_ctrl_pkg::*;
#(
   parameter int D     = 10,
   parameter int NPROG = 4,
   parameter int SW    = (NPROG > 1) ? $clog2(NPROG) : 1
) (
   input  logic [SW-1:0] idx,
   output logic [D-1:0]  start_addr,
   output logic [D-1:0]  end_addr
);

   always_comb begin
      start_addr = '0;
      end_addr   = '0;
      for (int i = 0; i < NPROG && i < MAX_PROG; i++) begin
         if (idx == SW'(i)) begin
            start_addr = START_DEF[i][D-1:0];
            end_addr   = END_DEF[i][D-1:0];
         end
      end
   end

endmodule

// File: rtl/run_ctrl.sv
// Program-run sequencer: req/done handshake, PC entry load, halt/END detect, cycle count.
// Optional watchdog enabled by defining RUN_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | core held in reset, waiting for req
// LOAD   | one cycle: release reset, load PC with entry address
// RUN    | core executing, counting cycles until halt/END (or watchdog)
// FINISH | done high, core in reset, waiting for req to drop
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int D       = 10,
   parameter int NPROG   = 4,
   parameter int SW      = (NPROG > 1) ? $clog2(NPROG) : 1,
   parameter int CW      = 16,
   parameter int MAX_CYC = 4096
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic [SW-1:0] prog_sel,
   input  logic [D-1:0]  prog_ctr,
   input  logic          halt,
   output logic          core_rst,
   output logic          pc_load,
   output logic [D-1:0]  pc_target,
   output logic          busy,
   output logic          done,
   output logic          sel_err,
   output logic [CW-1:0] cyc_cnt,
   output logic          timeout
);

   state_t        state, state_nxt;
   logic [SW-1:0] sel_q;
   logic [D-1:0]  start_addr, end_addr;
   logic          sel_bad, end_hit, wd_hit;
   logic          core_rst_d, pc_load_d, busy_d, done_d;

   prog_tbl #(.D(D), .NPROG(NPROG), .SW(SW)) u_prog_tbl (
      .idx        (sel_q),
      .start_addr (start_addr),
      .end_addr   (end_addr)
   );

   assign pc_target = start_addr;
   assign sel_bad   = (int'(prog_sel) >= NPROG);
   assign end_hit   = halt || (prog_ctr == end_addr);

`ifdef RUN_TIMEOUT_EN
   assign wd_hit = (cyc_cnt == CW'(MAX_CYC - 1));
`else
   logic unused_max_cyc;
   assign unused_max_cyc = (MAX_CYC != 0);
   assign wd_hit         = 1'b0;
`endif

   // Outputs are registered from the next state so they line up with state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         core_rst <= 1'b1;
         pc_load  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         core_rst <= core_rst_d;
         pc_load  <= pc_load_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (req) state_nxt = LOAD;
         LOAD:    state_nxt = RUN;
         RUN:     if (end_hit || wd_hit) state_nxt = FINISH;
         FINISH:  if (!req) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      core_rst_d = 1'b1;
      pc_load_d  = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      unique case (state_nxt)
         LOAD: begin
            core_rst_d = 1'b0;
            pc_load_d  = 1'b1;
            busy_d     = 1'b1;
         end
         RUN: begin
            core_rst_d = 1'b0;
            busy_d     = 1'b1;
         end
         FINISH:  done_d = 1'b1;
         default: ;
      endcase
   end

   // Count is cleared at acceptance so it already reads 0 during LOAD.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q   <= '0;
         sel_err <= 1'b0;
         cyc_cnt <= '0;
      end else if (state == IDLE && req) begin
         sel_q   <= sel_bad ? '0 : prog_sel;
         sel_err <= sel_bad ? SEL_ERR_BAD : ~SEL_ERR_BAD;
         cyc_cnt <= '0;
      end else if (state == RUN && cyc_cnt != '1) begin
         cyc_cnt <= cyc_cnt + 1'b1;
      end
   end

`ifdef RUN_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset)
         timeout <= 1'b0;
      else if (state == IDLE && req)
         timeout <= 1'b0;
      else if (state == RUN && wd_hit && !end_hit)
         timeout <= 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

endmodule
